// File: rtl/reorder_buffer.sv
// =============================================================================
// Module      : reorder_buffer
// Description : Circular in-order reorder buffer that feeds the commit stage.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package core_pkg;
    localparam int ISSUE_WIDTH = 2;
    localparam int ROB_ENTRIES = 16;
    localparam int LOG2_PREGS  = 6;
endpackage

module reorder_buffer #(
    parameter int COMMIT_W    = core_pkg::ISSUE_WIDTH,
    parameter int ROB_ENTRIES = core_pkg::ROB_ENTRIES,
    parameter int PHYS_W      = core_pkg::LOG2_PREGS,
    parameter int IDX_W       = $clog2(ROB_ENTRIES)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [COMMIT_W-1:0] alloc_valid,
    input  logic [4:0]          alloc_arch_rd        [COMMIT_W],
    input  logic [PHYS_W-1:0]   alloc_phys_rd        [COMMIT_W],
    input  logic [COMMIT_W-1:0] alloc_is_store,
    input  logic [COMMIT_W-1:0] alloc_is_load,
    input  logic [COMMIT_W-1:0] alloc_is_branch,
    input  logic [31:0]         alloc_pc             [COMMIT_W],
    output logic                alloc_ready,
    output logic [IDX_W-1:0]    alloc_rob_idx        [COMMIT_W],
    input  logic [COMMIT_W-1:0] wb_valid,
    input  logic [IDX_W-1:0]    wb_rob_idx           [COMMIT_W],
    input  logic [COMMIT_W-1:0] wb_exception,
    output logic [COMMIT_W-1:0] rob_commit_valid,
    output logic [4:0]          rob_commit_arch_rd   [COMMIT_W],
    output logic [PHYS_W-1:0]   rob_commit_phys_rd   [COMMIT_W],
    output logic [COMMIT_W-1:0] rob_commit_exception,
    output logic [COMMIT_W-1:0] rob_commit_is_store,
    output logic [COMMIT_W-1:0] rob_commit_is_load,
    output logic [COMMIT_W-1:0] rob_commit_is_branch,
    output logic [31:0]         rob_commit_pc        [COMMIT_W],
    output logic [IDX_W-1:0]    rob_commit_idx       [COMMIT_W],
    input  logic                flush_pipeline,
    output logic [IDX_W:0]      rob_count,
    output logic                rob_empty,
    output logic                rob_full
);

    localparam logic [IDX_W:0] c_depth = (IDX_W+1)'(ROB_ENTRIES);
    localparam logic [IDX_W:0] c_width = (IDX_W+1)'(COMMIT_W);
    localparam logic [IDX_W:0] c_one   = (IDX_W+1)'(1);

    logic [ROB_ENTRIES-1:0] valid_q, valid_d, done_q, done_d, exc_q, exc_d;
    logic [ROB_ENTRIES-1:0] is_store_q, is_store_d, is_load_q, is_load_d;
    logic [ROB_ENTRIES-1:0] is_branch_q, is_branch_d;
    logic [4:0]             arch_rd_q [ROB_ENTRIES];
    logic [4:0]             arch_rd_d [ROB_ENTRIES];
    logic [PHYS_W-1:0]      phys_rd_q [ROB_ENTRIES];
    logic [PHYS_W-1:0]      phys_rd_d [ROB_ENTRIES];
    logic [31:0]            pc_q      [ROB_ENTRIES];
    logic [31:0]            pc_d      [ROB_ENTRIES];
    logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]         count_q, count_d;
    logic                   exc_hold_q, exc_hold_d;

    logic [IDX_W-1:0]       slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0]    commit_ok;
    logic                   stop;
    logic                   exc_present;
    logic [IDX_W:0]         retire_n;
    logic [IDX_W:0]         alloc_n;

    always_comb begin
        alloc_ready = (c_depth - count_q) >= c_width;
        rob_count   = count_q;
        rob_empty   = (count_q == '0);
        rob_full    = (count_q == c_depth);
        for (int i = 0; i < COMMIT_W; i++) begin
            alloc_rob_idx[i] = tail_q + IDX_W'(i);
        end
    end

    // Oldest contiguous done entries; an excepting entry only ever appears alone in slot 0.
    always_comb begin
        stop        = exc_hold_q;
        exc_present = 1'b0;
        retire_n    = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot_idx[i]  = head_q + IDX_W'(i);
            commit_ok[i] = !stop && valid_q[slot_idx[i]] && done_q[slot_idx[i]]
                           && ((i == 0) || !exc_q[slot_idx[i]]);
            if (commit_ok[i] && exc_q[slot_idx[i]]) begin
                exc_present = 1'b1;
            end else if (commit_ok[i]) begin
                retire_n = retire_n + c_one;
            end
            if (!commit_ok[i] || exc_q[slot_idx[i]]) begin
                stop = 1'b1;
            end
            rob_commit_valid[i]     = commit_ok[i];
            rob_commit_arch_rd[i]   = arch_rd_q[slot_idx[i]];
            rob_commit_phys_rd[i]   = phys_rd_q[slot_idx[i]];
            rob_commit_exception[i] = exc_q[slot_idx[i]];
            rob_commit_is_store[i]  = is_store_q[slot_idx[i]];
            rob_commit_is_load[i]   = is_load_q[slot_idx[i]];
            rob_commit_is_branch[i] = is_branch_q[slot_idx[i]];
            rob_commit_pc[i]        = pc_q[slot_idx[i]];
            rob_commit_idx[i]       = slot_idx[i];
        end
    end

    always_comb begin
        valid_d     = valid_q;
        done_d      = done_q;
        exc_d       = exc_q;
        is_store_d  = is_store_q;
        is_load_d   = is_load_q;
        is_branch_d = is_branch_q;
        arch_rd_d   = arch_rd_q;
        phys_rd_d   = phys_rd_q;
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        exc_hold_d  = exc_hold_q;
        alloc_n     = '0;
        if (flush_pipeline) begin
            valid_d    = '0;
            done_d     = '0;
            exc_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            exc_hold_d = 1'b0;
        end else begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (wb_valid[i] && valid_q[wb_rob_idx[i]]) begin
                    done_d[wb_rob_idx[i]] = 1'b1;
                    exc_d[wb_rob_idx[i]]  = wb_exception[i];
                end
                if (commit_ok[i] && !exc_q[slot_idx[i]]) begin
                    valid_d[slot_idx[i]] = 1'b0;
                end
            end
            if (exc_present) begin
                exc_hold_d = 1'b1;
            end
            // Free slots at the tail are never the target of a same-cycle writeback or retire.
            if (alloc_ready) begin
                for (int i = 0; i < COMMIT_W; i++) begin
                    if (alloc_valid[i]) begin
                        valid_d[alloc_rob_idx[i]]     = 1'b1;
                        done_d[alloc_rob_idx[i]]      = 1'b0;
                        exc_d[alloc_rob_idx[i]]       = 1'b0;
                        is_store_d[alloc_rob_idx[i]]  = alloc_is_store[i];
                        is_load_d[alloc_rob_idx[i]]   = alloc_is_load[i];
                        is_branch_d[alloc_rob_idx[i]] = alloc_is_branch[i];
                        arch_rd_d[alloc_rob_idx[i]]   = alloc_arch_rd[i];
                        phys_rd_d[alloc_rob_idx[i]]   = alloc_phys_rd[i];
                        pc_d[alloc_rob_idx[i]]        = alloc_pc[i];
                        alloc_n                       = alloc_n + c_one;
                    end
                end
            end
            head_d  = head_q + retire_n[IDX_W-1:0];
            tail_d  = tail_q + alloc_n[IDX_W-1:0];
            count_d = count_q + alloc_n - retire_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= '0;
            done_q      <= '0;
            exc_q       <= '0;
            is_store_q  <= '0;
            is_load_q   <= '0;
            is_branch_q <= '0;
            arch_rd_q   <= '{default: '0};
            phys_rd_q   <= '{default: '0};
            pc_q        <= '{default: '0};
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            exc_hold_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
            is_store_q  <= is_store_d;
            is_load_q   <= is_load_d;
            is_branch_q <= is_branch_d;
            arch_rd_q   <= arch_rd_d;
            phys_rd_q   <= phys_rd_d;
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            exc_hold_q  <= exc_hold_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// =============================================================================
// Module      : tb_reorder_buffer
// Description : Scoreboard bench for reorder_buffer (COMMIT_W=2, 16 entries).
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_reorder_buffer;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  alloc_valid;
    logic [4:0]  alloc_arch_rd [2];
    logic [5:0]  alloc_phys_rd [2];
    logic [1:0]  alloc_is_store, alloc_is_load, alloc_is_branch;
    logic [31:0] alloc_pc [2];
    logic        alloc_ready;
    logic [3:0]  alloc_rob_idx [2];
    logic [1:0]  wb_valid;
    logic [3:0]  wb_rob_idx [2];
    logic [1:0]  wb_exception;
    logic [1:0]  rob_commit_valid;
    logic [4:0]  rob_commit_arch_rd [2];
    logic [5:0]  rob_commit_phys_rd [2];
    logic [1:0]  rob_commit_exception;
    logic [1:0]  rob_commit_is_store, rob_commit_is_load, rob_commit_is_branch;
    logic [31:0] rob_commit_pc [2];
    logic [3:0]  rob_commit_idx [2];
    logic        flush_pipeline;
    logic [4:0]  rob_count;
    logic        rob_empty, rob_full;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_commits = 0;
    exp_t        sb [$];
    exp_t        mon_e;
    logic [3:0]  m_tail = '0;
    logic        model_exc [16];

    reorder_buffer #(.COMMIT_W(2), .ROB_ENTRIES(16), .PHYS_W(6), .IDX_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_arch_rd(alloc_arch_rd), .alloc_phys_rd(alloc_phys_rd),
        .alloc_is_store(alloc_is_store), .alloc_is_load(alloc_is_load),
        .alloc_is_branch(alloc_is_branch), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_rob_idx(alloc_rob_idx),
        .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_exception(wb_exception),
        .rob_commit_valid(rob_commit_valid), .rob_commit_arch_rd(rob_commit_arch_rd),
        .rob_commit_phys_rd(rob_commit_phys_rd), .rob_commit_exception(rob_commit_exception),
        .rob_commit_is_store(rob_commit_is_store), .rob_commit_is_load(rob_commit_is_load),
        .rob_commit_is_branch(rob_commit_is_branch), .rob_commit_pc(rob_commit_pc),
        .rob_commit_idx(rob_commit_idx), .flush_pipeline(flush_pipeline),
        .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        alloc_valid    = '0;
        wb_valid       = '0;
        flush_pipeline = 1'b0;
    endtask

    // Payload fields are derived from the PC so the monitor can recompute them.
    task automatic drive_alloc(input int n, input logic [31:0] pc0);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] pc;
            pc                 = pc0 + 32'(4 * i);
            alloc_valid[i]     = (i < n);
            alloc_pc[i]        = pc;
            alloc_arch_rd[i]   = pc[6:2];
            alloc_phys_rd[i]   = pc[7:2];
            alloc_is_load[i]   = pc[2];
            alloc_is_store[i]  = pc[3];
            alloc_is_branch[i] = pc[4];
        end
    endtask

    task automatic do_alloc(input int n, input logic [31:0] pc0, input bit accept);
        drive_alloc(n, pc0);
        if (accept) begin
            for (int i = 0; i < n; i++) begin
                sb.push_back('{idx: m_tail, pc: pc0 + 32'(4 * i)});
                model_exc[m_tail] = 1'b0;
                m_tail = m_tail + 4'd1;
            end
        end
        cyc();
    endtask

    task automatic set_wb(input int port, input logic [3:0] idx, input logic exc);
        wb_valid[port]     = 1'b1;
        wb_rob_idx[port]   = idx;
        wb_exception[port] = exc;
        model_exc[idx]     = exc;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (rob_commit_valid[i]) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_commit: got idx 0x%0h expected no commit", rob_commit_idx[i]);
                    end else begin
                        mon_e = sb.pop_front();
                        n_commits++;
                        chk("commit_idx", 32'(rob_commit_idx[i]), 32'(mon_e.idx));
                        chk("commit_pc", rob_commit_pc[i], mon_e.pc);
                        chk("commit_arch_rd", 32'(rob_commit_arch_rd[i]), 32'(mon_e.pc[6:2]));
                        chk("commit_phys_rd", 32'(rob_commit_phys_rd[i]), 32'(mon_e.pc[7:2]));
                        chk("commit_is_load", 32'(rob_commit_is_load[i]), 32'(mon_e.pc[2]));
                        chk("commit_exc", 32'(rob_commit_exception[i]), 32'(model_exc[mon_e.idx]));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] base;
        alloc_valid = '0; wb_valid = '0; wb_exception = '0; flush_pipeline = 1'b0;
        alloc_is_store = '0; alloc_is_load = '0; alloc_is_branch = '0;
        for (int i = 0; i < 2; i++) begin
            alloc_arch_rd[i] = '0; alloc_phys_rd[i] = '0; alloc_pc[i] = '0; wb_rob_idx[i] = '0;
        end
        for (int i = 0; i < 16; i++) model_exc[i] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_empty", 32'(rob_empty), 1);
        chk("reset_full", 32'(rob_full), 0);
        chk("reset_ready", 32'(alloc_ready), 1);
        chk("reset_count", 32'(rob_count), 0);
        chk("reset_alloc_idx1", 32'(alloc_rob_idx[1]), 1);
        chk("reset_commit_valid", 32'(rob_commit_valid), 0);

        // Asynchronous reset with five entries outstanding
        do_alloc(2, 32'h40, 1); do_alloc(2, 32'h48, 1); do_alloc(1, 32'h50, 1);
        chk("pre_reset_count", 32'(rob_count), 5);
        chk("pre_reset_alloc_idx0", 32'(alloc_rob_idx[0]), 5);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_count", 32'(rob_count), 0);
        chk("async_reset_empty", 32'(rob_empty), 1);
        chk("async_reset_ready", 32'(alloc_ready), 1);
        chk("async_reset_alloc_idx0", 32'(alloc_rob_idx[0]), 0);
        chk("async_reset_alloc_idx1", 32'(alloc_rob_idx[1]), 1);
        sb.delete(); m_tail = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk("post_reset_empty", 32'(rob_empty), 1);
        chk("post_reset_alloc_idx1", 32'(alloc_rob_idx[1]), 1);

        // In-order retire with out-of-order completion
        do_alloc(2, 32'h100, 1); do_alloc(2, 32'h108, 1);
        chk("inorder_count4", 32'(rob_count), 4);
        set_wb(0, 4'd3, 1'b0); cyc();
        chk("inorder_wait_a", 32'(rob_commit_valid), 0);
        set_wb(0, 4'd1, 1'b0); cyc();
        chk("inorder_wait_b", 32'(rob_commit_valid), 0);
        set_wb(0, 4'd0, 1'b0); cyc();
        chk("inorder_first_pair", 32'(rob_commit_valid), 32'h3);
        chk("inorder_count_before", 32'(rob_count), 4);
        set_wb(0, 4'd2, 1'b0); cyc();
        chk("inorder_second_pair", 32'(rob_commit_valid), 32'h3);
        chk("inorder_count_mid", 32'(rob_count), 2);
        cyc();
        chk("inorder_drained", 32'(rob_count), 0);
        chk("inorder_idle", 32'(rob_commit_valid), 0);

        // Flush to zero indices, then fill to capacity
        flush_pipeline = 1'b1; cyc(); m_tail = '0;
        chk("flush_alloc_idx0", 32'(alloc_rob_idx[0]), 0);
        for (int k = 0; k < 7; k++) do_alloc(2, 32'h200 + 32'(8 * k), 1);
        chk("fill_count14", 32'(rob_count), 14);
        chk("fill_ready14", 32'(alloc_ready), 1);
        chk("fill_alloc_idx14", 32'(alloc_rob_idx[0]), 14);
        do_alloc(2, 32'h238, 1);
        chk("fill_count16", 32'(rob_count), 16);
        chk("fill_full", 32'(rob_full), 1);
        chk("fill_not_ready", 32'(alloc_ready), 0);
        do_alloc(2, 32'hDEAD0, 0);
        chk("fill_ignored_count", 32'(rob_count), 16);
        chk("fill_ignored_tail", 32'(alloc_rob_idx[0]), 0);
        for (int k = 0; k < 8; k++) begin
            set_wb(0, 4'(2 * k), 1'b0);
            set_wb(1, 4'(2 * k + 1), 1'b0);
            cyc();
        end
        repeat (2) cyc();
        chk("fill_drained", 32'(rob_count), 0);

        // Wrap-around: 20 instructions through the buffer
        for (int k = 0; k < 10; k++) begin
            base = m_tail;
            do_alloc(2, 32'h300 + 32'(8 * k), 1);
            set_wb(0, base, 1'b0);
            set_wb(1, base + 4'd1, 1'b0);
            cyc();
            cyc();
        end
        chk("wrap_drained", 32'(rob_count), 0);
        chk("wrap_tail", 32'(alloc_rob_idx[0]), 4);

        // Allocate two while retiring two
        do_alloc(2, 32'h400, 1); do_alloc(2, 32'h408, 1); do_alloc(2, 32'h410, 1);
        chk("simul_count6", 32'(rob_count), 6);
        set_wb(0, 4'd4, 1'b0); set_wb(1, 4'd5, 1'b0); cyc();
        chk("simul_commit", 32'(rob_commit_valid), 32'h3);
        do_alloc(2, 32'h418, 1);
        chk("simul_count_kept", 32'(rob_count), 6);

        // Flush with concurrent allocate and writeback
        set_wb(0, 4'd6, 1'b0);
        drive_alloc(2, 32'h420);
        flush_pipeline = 1'b1;
        cyc();
        sb.delete(); m_tail = '0;
        chk("flush_count", 32'(rob_count), 0);
        chk("flush_empty", 32'(rob_empty), 1);
        chk("flush_alloc_idx1", 32'(alloc_rob_idx[1]), 1);
        set_wb(0, 4'd0, 1'b0); set_wb(1, 4'd1, 1'b0); cyc(); cyc();
        chk("flush_no_commit", 32'(rob_commit_valid), 0);
        chk("flush_count_after_wb", 32'(rob_count), 0);

        // Exception held alone in slot 0 until flush
        do_alloc(2, 32'h500, 1); do_alloc(1, 32'h508, 1);
        set_wb(0, 4'd0, 1'b0); set_wb(1, 4'd1, 1'b1); cyc();
        chk("exc_cycleA_valid", 32'(rob_commit_valid), 32'h1);
        chk("exc_cycleA_count", 32'(rob_count), 3);
        set_wb(0, 4'd2, 1'b0); cyc();
        chk("exc_cycleA1_valid", 32'(rob_commit_valid), 32'h1);
        chk("exc_cycleA1_flag", 32'(rob_commit_exception[0]), 1);
        chk("exc_cycleA1_idx", 32'(rob_commit_idx[0]), 1);
        chk("exc_cycleA1_count", 32'(rob_count), 2);
        cyc();
        chk("exc_hold_a", 32'(rob_commit_valid), 0);
        chk("exc_hold_count", 32'(rob_count), 2);
        cyc();
        chk("exc_hold_b", 32'(rob_commit_valid), 0);
        flush_pipeline = 1'b1; cyc();
        sb.delete(); m_tail = '0;
        chk("exc_flush_count", 32'(rob_count), 0);
        chk("exc_flush_alloc_idx0", 32'(alloc_rob_idx[0]), 0);
        chk("exc_flush_commit", 32'(rob_commit_valid), 0);

        chk("total_commits", 32'(n_commits), 44);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
